// File: rtl/simplebus_mem_slave.sv
// simplebus_mem_slave: memory-backed SimpleBus responder with single/burst read/write, probe and prefetch.
// Define SIMPLEBUS_MEM_ERRCHK_EN to add the sticky err output and protocol checking.
module simplebus_mem_slave #(
  parameter int DEPTH_WORDS = 1024,
  parameter int BURST_LEN   = 4,
  parameter int RD_LATENCY  = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [3:0]  req_cmd,
  input  logic [7:0]  req_wmask,
  input  logic [63:0] req_wdata,
  input  logic [15:0] req_user,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [3:0]  resp_cmd,
  output logic [63:0] resp_rdata,
  output logic [15:0] resp_user
`ifdef SIMPLEBUS_MEM_ERRCHK_EN
  ,
  output logic        err
`endif
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int BW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
  localparam logic [AW-1:0] BMASK = AW'(BURST_LEN - 1);
  localparam logic [3:0] CMD_READ        = 4'b0000;
  localparam logic [3:0] CMD_WRITE       = 4'b0001;
  localparam logic [3:0] CMD_READ_BURST  = 4'b0010;
  localparam logic [3:0] CMD_WRITE_BURST = 4'b0011;
  localparam logic [3:0] CMD_PREFETCH    = 4'b0100;
  localparam logic [3:0] CMD_WRITE_RESP  = 4'b0101;
  localparam logic [3:0] CMD_READ_LAST   = 4'b0110;
  localparam logic [3:0] CMD_WRITE_LAST  = 4'b0111;
  localparam logic [3:0] CMD_PROBE       = 4'b1000;
  localparam logic [3:0] CMD_PROBE_MISS  = 4'b1000;
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD_WAIT  = 3'd1;
  localparam logic [2:0] S_RD_DATA  = 3'd2;
  localparam logic [2:0] S_WR_BURST = 3'd3;
  localparam logic [2:0] S_WR_RESP  = 3'd4;

  logic [2:0]    state;
  logic [AW-1:0] idx;
  logic [AW-1:0] req_idx;
  logic [AW-1:0] nxt_idx;
  logic [AW-1:0] wr_idx;
  logic [BW-1:0] beat_cnt;
  logic [3:0]    lat_cnt;
  logic          probe_q;
  logic [15:0]   user_q;
  logic [63:0]   mem [DEPTH_WORDS];
  logic          acc;
  logic          resp_acc;
  logic          wr_en;
  logic          unused_ok;

  assign unused_ok = ^{req_size, req_addr[31:3+AW], req_addr[2:0]};
  assign req_idx = req_addr[3 +: AW];
  // critical-word-first: only the low index bits advance, wrapping inside the aligned block
  assign nxt_idx = (idx & ~BMASK) | ((idx + 1'b1) & BMASK);
  assign req_ready = reset && (state == S_IDLE || state == S_WR_BURST);
  assign acc = req_valid && req_ready;
  assign resp_valid = state == S_RD_DATA || state == S_WR_RESP;
  assign resp_acc = resp_valid && resp_ready;
  assign resp_cmd = state == S_RD_DATA ? (beat_cnt == '0 ? CMD_READ_LAST : CMD_READ) :
                    state == S_WR_RESP ? (probe_q ? CMD_PROBE_MISS : CMD_WRITE_RESP) : 4'b0000;
  assign resp_rdata = state == S_RD_DATA ? mem[idx] : '0;
  assign resp_user = user_q;
  assign wr_en = acc && (state == S_IDLE ? (req_cmd == CMD_WRITE || req_cmd == CMD_WRITE_BURST) :
                                           (req_cmd == CMD_WRITE_BURST || req_cmd == CMD_WRITE_LAST));
  assign wr_idx = state == S_IDLE ? req_idx : nxt_idx;

  always_ff @(posedge clock)
    if (wr_en)
      for (int i = 0; i < 8; i++)
        if (req_wmask[i]) mem[wr_idx][8*i +: 8] <= req_wdata[8*i +: 8];

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state    <= S_IDLE;
      idx      <= '0;
      beat_cnt <= '0;
      lat_cnt  <= '0;
      probe_q  <= 1'b0;
      user_q   <= '0;
    end else begin
      case (state)
        S_IDLE:
          if (acc) begin
            user_q   <= req_user;
            idx      <= req_idx;
            probe_q  <= req_cmd == CMD_PROBE;
            beat_cnt <= req_cmd == CMD_READ_BURST ? BW'(BURST_LEN - 1) : '0;
            lat_cnt  <= '0;
            state    <= (req_cmd == CMD_READ || req_cmd == CMD_READ_BURST) ? S_RD_WAIT :
                        req_cmd == CMD_WRITE_BURST ? S_WR_BURST :
                        (req_cmd == CMD_WRITE || req_cmd == CMD_PROBE) ? S_WR_RESP : S_IDLE;
          end
        S_RD_WAIT: begin
          lat_cnt <= lat_cnt + 4'd1;
          if (lat_cnt == 4'(RD_LATENCY)) state <= S_RD_DATA;
        end
        S_RD_DATA:
          if (resp_acc) begin
            idx      <= nxt_idx;
            beat_cnt <= beat_cnt - 1'b1;
            if (beat_cnt == '0) state <= S_IDLE;
          end
        S_WR_BURST:
          if (acc) begin
            if (wr_en) idx <= nxt_idx;
            state <= req_cmd == CMD_WRITE_BURST ? S_WR_BURST : S_WR_RESP;
          end
        S_WR_RESP:
          if (resp_acc) begin
            probe_q <= 1'b0;
            state   <= S_IDLE;
          end
        default: state <= S_IDLE;
      endcase
    end

`ifdef SIMPLEBUS_MEM_ERRCHK_EN
  logic        stall_q;
  logic [3:0]  cmd_q;
  logic [31:0] addr_q;
  logic [63:0] wdata_q;
  logic        cmd_ok;
  logic        err_set;

  assign cmd_ok = state == S_IDLE ?
    req_cmd inside {CMD_READ, CMD_READ_BURST, CMD_WRITE, CMD_WRITE_BURST, CMD_PROBE, CMD_PREFETCH} :
    req_cmd inside {CMD_WRITE_BURST, CMD_WRITE_LAST};
  // a stalled request must hold its payload until it is accepted
  assign err_set = (acc && (!cmd_ok || req_addr[31:3+AW] != '0)) ||
                   (stall_q && req_valid && {req_cmd, req_addr, req_wdata} != {cmd_q, addr_q, wdata_q});

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      err     <= 1'b0;
      stall_q <= 1'b0;
      cmd_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      err     <= err | err_set;
      stall_q <= req_valid && !req_ready;
      cmd_q   <= req_cmd;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end

`ifndef SYNTHESIS
  always @(posedge clock)
    if (reset && err_set) $error("simplebus_mem_slave: protocol error cmd=%h addr=%h", req_cmd, req_addr);
`endif
`endif
endmodule

// File: tb/tb_simplebus_mem_slave.sv
// tb_simplebus_mem_slave: directed bench with a transaction-level memory model and per-cycle response checker.
module tb_simplebus_mem_slave;
  localparam int LAT = 2;
  localparam logic [3:0] RD = 4'h0, WR = 4'h1, RDB = 4'h2, WRB = 4'h3, PF = 4'h4,
                         WRSP = 4'h5, RDL = 4'h6, WRL = 4'h7, PRB = 4'h8;

  logic        clock, reset;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_size;
  logic [3:0]  req_cmd;
  logic [7:0]  req_wmask;
  logic [63:0] req_wdata;
  logic [15:0] req_user;
  logic        resp_valid, resp_ready;
  logic [3:0]  resp_cmd;
  logic [63:0] resp_rdata;
  logic [15:0] resp_user;

  simplebus_mem_slave #(.DEPTH_WORDS(1024), .BURST_LEN(4), .RD_LATENCY(LAT)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_size(req_size),
    .req_cmd(req_cmd), .req_wmask(req_wmask), .req_wdata(req_wdata), .req_user(req_user),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_cmd(resp_cmd),
    .resp_rdata(resp_rdata), .resp_user(resp_user)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int last_wait;

  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask

  // transaction-level model: word array plus queue of expected response beats
  typedef struct packed { logic [3:0] c; logic [63:0] d; logic [15:0] u; } beat_t;
  beat_t       q[$];
  logic [63:0] mdl [1024];
  bit          in_wb;
  int          wb_idx;
  logic [15:0] wb_user;

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 3) & 32'h3ff);
  endfunction

  function automatic int wrap(input int i, input int k);
    return (i & ~3) | ((i + k) & 3);
  endfunction

  task automatic mwrite(input int i, input logic [63:0] d, input logic [7:0] m);
    for (int b = 0; b < 8; b++) if (m[b]) mdl[i][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic model_accept();
    int i;
    i = widx(req_addr);
    if (in_wb) begin
      if (req_cmd == WRB || req_cmd == WRL) begin
        wb_idx = wrap(wb_idx, 1);
        mwrite(wb_idx, req_wdata, req_wmask);
      end
      if (req_cmd != WRB) begin
        q.push_back('{WRSP, 64'h0, wb_user});
        in_wb = 0;
      end
    end else begin
      case (req_cmd)
        RD:  q.push_back('{RDL, mdl[i], req_user});
        RDB: for (int k = 0; k < 4; k++) q.push_back('{k == 3 ? RDL : RD, mdl[wrap(i, k)], req_user});
        WR: begin
          mwrite(i, req_wdata, req_wmask);
          q.push_back('{WRSP, 64'h0, req_user});
        end
        WRB: begin
          mwrite(i, req_wdata, req_wmask);
          in_wb = 1; wb_idx = i; wb_user = req_user;
        end
        PRB: q.push_back('{PRB, 64'h0, req_user});
        default: ;
      endcase
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      q.delete();
      in_wb = 0;
      chk("rst_resp_valid", {63'h0, resp_valid}, 64'h0);
      chk("rst_req_ready", {63'h0, req_ready}, 64'h0);
    end else begin
      if (resp_valid) begin
        chk("busy_req_ready", {63'h0, req_ready}, 64'h0);
        if (q.size() == 0) chk("unexpected_resp", {63'h0, resp_valid}, 64'h0);
        else begin
          chk("mdl_resp_cmd", {60'h0, resp_cmd}, {60'h0, q[0].c});
          chk("mdl_resp_rdata", resp_rdata, q[0].d);
          chk("mdl_resp_user", {48'h0, resp_user}, {48'h0, q[0].u});
          if (resp_ready) void'(q.pop_front());
        end
      end
      if (req_valid && req_ready) model_accept();
    end
  end

  task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [63:0] d,
                      input logic [7:0] m, input logic [15:0] u);
    @(posedge clock); #1;
    req_valid = 1; req_cmd = c; req_addr = a; req_wdata = d; req_wmask = m; req_user = u;
    last_wait = -1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clock);
      if (req_ready) begin
        last_wait = t + 1;
        break;
      end
    end
    if (last_wait < 0) chk("send_timeout", {63'h0, req_ready}, 64'h1);
    else begin
      @(posedge clock); #1;
    end
    req_valid = 0;
  endtask

  task automatic get_resp(output logic [3:0] c, output logic [63:0] d, output logic [15:0] u, output int k);
    k = -1; c = 'x; d = 'x; u = 'x;
    for (int t = 1; t <= 100; t++) begin
      @(negedge clock);
      if (resp_valid) begin
        c = resp_cmd; d = resp_rdata; u = resp_user; k = t;
        break;
      end
    end
    if (k < 0) chk("resp_timeout", {63'h0, resp_valid}, 64'h1);
  endtask

  task automatic read1(input logic [31:0] a, input logic [63:0] exp, input string n);
    logic [3:0] c; logic [63:0] d; logic [15:0] u; int k;
    send(RD, a, 64'h0, 8'h0, 16'h1);
    get_resp(c, d, u, k);
    chk(n, d, exp);
  endtask

  initial begin
    logic [3:0] c; logic [63:0] d; logic [15:0] u; int k; int seen;
    logic [63:0] exp_burst [4];
    clock = 0; reset = 0; req_valid = 0; req_addr = 0; req_size = 3'd3; req_cmd = 0;
    req_wmask = 0; req_wdata = 0; req_user = 0; resp_ready = 1;
    repeat (3) @(negedge clock);
    chk("reset_req_ready", {63'h0, req_ready}, 64'h0);
    chk("reset_resp_valid", {63'h0, resp_valid}, 64'h0);
    chk("reset_resp_cmd", {60'h0, resp_cmd}, 64'h0);
    chk("reset_resp_rdata", resp_rdata, 64'h0);
    chk("reset_resp_user", {48'h0, resp_user}, 64'h0);
    @(posedge clock); #1 reset = 1;

    send(WR, 32'h100, 64'h1122334455667788, 8'hFF, 16'h5);
    get_resp(c, d, u, k);
    chk("wr_cmd", {60'h0, c}, 64'h5);
    chk("wr_user", {48'h0, u}, 64'h5);
    chk("wr_rdata", d, 64'h0);
    send(RD, 32'h100, 64'h0, 8'h0, 16'h7);
    get_resp(c, d, u, k);
    chk("rd_latency", 64'(k - 1), 64'd3);
    chk("rd_cmd", {60'h0, c}, 64'h6);
    chk("rd_data", d, 64'h1122334455667788);
    chk("rd_user", {48'h0, u}, 64'h7);

    send(WR, 32'h100, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 16'h9);
    get_resp(c, d, u, k);
    chk("mwr_cmd", {60'h0, c}, 64'h5);
    read1(32'h100, 64'h11223344AAAAAAAA, "masked_read");
    send(WR, 32'h100, 64'hFFFFFFFFFFFFFFFF, 8'h00, 16'hA);
    get_resp(c, d, u, k);
    chk("nomask_cmd", {60'h0, c}, 64'h5);
    read1(32'h100, 64'h11223344AAAAAAAA, "nomask_read");

    for (int i = 0; i < 4; i++) begin
      send(WR, 32'h40 + 32'(8 * i), 64'(i), 8'hFF, 16'h2);
      get_resp(c, d, u, k);
    end
    send(RDB, 32'h50, 64'h0, 8'h0, 16'h33);
    exp_burst = '{64'h2, 64'h3, 64'h0, 64'h1};
    for (int i = 0; i < 4; i++) begin
      get_resp(c, d, u, k);
      chk("rdb_data", d, exp_burst[i]);
      chk("rdb_cmd", {60'h0, c}, i == 3 ? 64'h6 : 64'h0);
      chk("rdb_user", {48'h0, u}, 64'h33);
    end

    send(WRB, 32'h200, 64'hA0A0A0A0A0A0A0A0, 8'hFF, 16'h44);
    send(WRB, 32'h0, 64'hB1B1B1B1B1B1B1B1, 8'hFF, 16'h0);
    send(WRB, 32'h0, 64'hC2C2C2C2C2C2C2C2, 8'hFF, 16'h0);
    send(WRL, 32'h0, 64'hD3D3D3D3D3D3D3D3, 8'hFF, 16'h0);
    resp_ready = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("bp_valid", {63'h0, resp_valid}, 64'h1);
      chk("bp_cmd", {60'h0, resp_cmd}, 64'h5);
      chk("bp_req_ready", {63'h0, req_ready}, 64'h0);
    end
    @(posedge clock); #1 resp_ready = 1;
    get_resp(c, d, u, k);
    chk("wrb_user", {48'h0, u}, 64'h44);
    read1(32'h200, 64'hA0A0A0A0A0A0A0A0, "wrb_a");
    read1(32'h208, 64'hB1B1B1B1B1B1B1B1, "wrb_b");
    read1(32'h210, 64'hC2C2C2C2C2C2C2C2, "wrb_c");
    read1(32'h218, 64'hD3D3D3D3D3D3D3D3, "wrb_d");

    send(WRB, 32'h238, 64'hEEEE, 8'hFF, 16'h55);
    send(WRL, 32'h0, 64'hFFFF, 8'hFF, 16'h56);
    get_resp(c, d, u, k);
    chk("wrap_wr_user", {48'h0, u}, 64'h55);
    read1(32'h220, 64'hFFFF, "wrap_wr_f");
    read1(32'h238, 64'hEEEE, "wrap_wr_e");

    send(PRB, 32'h300, 64'h0, 8'h0, 16'h66);
    get_resp(c, d, u, k);
    chk("probe_cmd", {60'h0, c}, 64'h8);
    chk("probe_user", {48'h0, u}, 64'h66);
    send(PF, 32'h300, 64'h0, 8'h0, 16'h67);
    seen = 0;
    repeat (20) begin
      @(negedge clock);
      if (resp_valid) seen++;
    end
    chk("pf_no_resp", 64'(seen), 64'h0);
    read1(32'h200, 64'hA0A0A0A0A0A0A0A0, "pf_next_read");
    chk("pf_next_accept", 64'(last_wait), 64'h1);

    send(4'hF, 32'h100, 64'h0, 8'hFF, 16'h68);
    chk("illegal_accept", 64'(last_wait), 64'h1);
    seen = 0;
    repeat (5) begin
      @(negedge clock);
      if (resp_valid) seen++;
    end
    chk("illegal_no_resp", 64'(seen), 64'h0);
    read1(32'h100, 64'h11223344AAAAAAAA, "illegal_no_write");

    send(WR, 32'h2100, 64'hCAFEF00DDEADBEEF, 8'hFF, 16'h69);
    get_resp(c, d, u, k);
    read1(32'h100, 64'hCAFEF00DDEADBEEF, "alias_read");

    send(RDB, 32'h50, 64'h0, 8'h0, 16'h70);
    get_resp(c, d, u, k);
    chk("rstb_beat1", d, 64'h2);
    @(posedge clock); #1;
    chk("rstb_beat2_valid", {63'h0, resp_valid}, 64'h1);
    #2 reset = 0;
    #1;
    chk("async_rst_valid", {63'h0, resp_valid}, 64'h0);
    chk("async_rst_ready", {63'h0, req_ready}, 64'h0);
    @(posedge clock); #1 reset = 1;
    @(negedge clock);
    chk("post_rst_ready", {63'h0, req_ready}, 64'h1);
    send(RDB, 32'h40, 64'h0, 8'h0, 16'h77);
    for (int i = 0; i < 4; i++) begin
      get_resp(c, d, u, k);
      chk("post_rst_data", d, 64'(i));
    end

    repeat (5) @(negedge clock);
    chk("model_drained", 64'(q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failures %0d", tests, fails);
    $fatal(1);
  end
endmodule

// File: doc/simplebus_mem_slave.md
Name: simplebus_mem_slave

Overview:
- Memory-backed SimpleBus responder that sits directly downstream of a simplebus_if master port.
- Accepts req-channel commands (single and burst read/write, probe, prefetch) and produces resp-channel beats.
- Backed by an internal 64-bit word array.
- Used as the memory endpoint behind the cache under test in UVM and toffee benches; also a reference slave for bus-level checks.

Parameters:
- DEPTH_WORDS, 1024, number of 64-bit words in the array; index = req_addr[3 +: log2(DEPTH_WORDS)], upper bits ignored (aliasing).
- BURST_LEN, 4, beats per read burst; must be a power of two.
- RD_LATENCY, 2, idle cycles between read-request acceptance and first resp beat; range 0..15.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accept.
- req_addr  in  32  byte address.
- req_size  in  3  log2 bytes; informational, not used for masking.
- req_cmd  in  4  cmd_t encoding.
- req_wmask  in  8  byte write enables.
- req_wdata  in  64  write data.
- req_user  in  16  user tag.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response accept.
- resp_cmd  out  4  response command.
- resp_rdata  out  64  read data.
- resp_user  out  16  echoed user tag.
- err  out  1  sticky protocol error; present only with SIMPLEBUS_MEM_ERRCHK_EN.

Behaviour:
- Handshake: a transfer occurs on a rising clock edge with valid && ready. resp_valid, resp_cmd, resp_rdata and resp_user are held stable until resp_ready.
- Reset values (asserted): state=IDLE; req_ready=0; resp_valid=0; resp_cmd=0; resp_rdata=0; resp_user=0; err=0. The memory array is not cleared.
- Reset mid-transaction: returns to IDLE and drops resp_valid immediately (asynchronous). A partially written burst keeps the beats already written.
- States: IDLE, RD_WAIT, RD_DATA, WR_BURST, WR_RESP.
- req_ready=1 only in IDLE and WR_BURST, and only when not in reset.
- IDLE, on accept:
  - READ_CMD: latch addr and user; beat_cnt = BURST_LEN-1 is not used; single beat; go to RD_WAIT.
  - READ_BURST_CMD: latch addr and user; beat_cnt = BURST_LEN-1; go to RD_WAIT.
  - WRITE_CMD: write array under wmask in the same edge; go to WR_RESP.
  - WRITE_BURST_CMD: write beat 0; latch user; go to WR_BURST.
  - PROBE_CMD: go to WR_RESP, with resp_cmd 4'b1000 (probe miss) instead of the write response.
  - PREFETCH_CMD: consumed, no response, stay in IDLE.
  - Any other cmd: consumed, no response; sets err.
- RD_WAIT: latency counter counts RD_LATENCY cycles, then go to RD_DATA. With RD_LATENCY=0, RD_DATA is entered on the edge after accept (1-cycle minimum req-to-resp).
- RD_DATA:
  - resp_valid=1; resp_rdata = array word at the current index.
  - resp_cmd = READ_LAST_CMD on the final beat, otherwise READ_CMD (4'b0000).
  - Burst address is critical-word-first and wraps within the aligned BURST_LEN*8-byte block: index low bits increment modulo BURST_LEN.
  - On resp handshake: decrement beat_cnt; after the last beat go to IDLE.
- WR_BURST:
  - Each accepted beat writes at the next index, with the same wrap rule.
  - WRITE_BURST_CMD beats stay in WR_BURST; WRITE_LAST_CMD writes, then goes to WR_RESP.
  - Any other cmd is consumed without a write, sets err, and goes to WR_RESP.
  - Burst length is not enforced.
- WR_RESP: resp_valid=1; resp_cmd=WRITE_RESP_CMD (or 4'b1000 for probe); resp_rdata=0. On resp_ready, go to IDLE.
- resp_user always equals the req_user latched at the first beat.
- Byte-mask write: byte i is updated iff wmask[i]. wmask=0 is a legal no-op write that still produces a response.
- Read-after-write: a read accepted on the cycle after a write's response returns the new data. There is no bypass hazard, because req_ready=0 while a response is pending.

Optional Feature:
- Macro: SIMPLEBUS_MEM_ERRCHK_EN.
- Defined:
  - err port exists.
  - err sets on: an illegal cmd in IDLE; a non-burst cmd in WR_BURST; req_addr index bits beyond DEPTH_WORDS nonzero; any of req_cmd, req_addr or req_wdata changing while req_valid=1 && req_ready=0.
  - err stays sticky until reset.
  - A $error message is emitted in simulation.
- Undefined: no err port, no checking logic; aliasing and illegal cmds are silently tolerated as described.

Test Plan:
- Write then read: WRITE_CMD addr 0x100, wdata 0x1122334455667788, wmask 0xFF, user 0x5 -> one resp beat, cmd 0x5, user 0x5. Then READ_CMD 0x100 -> after RD_LATENCY+1 cycles, one beat: cmd 0x6, rdata 0x1122334455667788.
- Masked write: wmask 0x0F, wdata 0xAAAAAAAAAAAAAAAA over the word above -> read returns 0x11223344AAAAAAAA.
- Wrapping read burst: preload words 0x40..0x58 with 0,1,2,3; READ_BURST_CMD addr 0x50 -> beats 2,3,0,1; cmds 0x0,0x0,0x0,0x6.
- Write burst under backpressure: WRITE_BURST 0x200, then 2×WRITE_BURST, then WRITE_LAST with data A,B,C,D; resp_ready held low 5 cycles -> resp_valid held, cmd 0x5 stable, req_ready=0; later reads return A..D.
- Probe and prefetch: PROBE_CMD -> single beat cmd 0x8. PREFETCH_CMD -> no resp_valid for 20 cycles, and the next request is accepted immediately.
- Reset mid-burst: assert reset during beat 2 of a read burst -> resp_valid=0 immediately; after release, req_ready=1 next cycle and memory contents are unchanged. With SIMPLEBUS_MEM_ERRCHK_EN, cmd 0xF -> err=1.
